// File: rtl/ign_inj_sim.sv
// Ignition pulse generator and injector puff capture for an engine simulator.
// Optional PUFF_MAX tracking is enabled by defining IGN_INJ_SIM_PUFF_MAX_EN.
module ign_inj_sim #(
    parameter int NUM_IGN = 2,
    parameter int NUM_INJ = 2,
    parameter int WIDTH   = 16
) (
    input  logic               sysclk,
    input  logic               sysreset,
    input  logic               sim_run,
    input  logic               pulse50k,
    input  logic               pulse1m,
    input  logic [6:0]         reg_addr,
    input  logic               reg_load,
    input  logic [WIDTH-1:0]   data_in,
    output logic [WIDTH-1:0]   data_out,
    output logic [NUM_IGN-1:0] ign_coil_lo,
    output logic [NUM_IGN-1:0] ign_pulse_end,
    input  logic [NUM_INJ-1:0] inj_open,
    output logic [NUM_INJ-1:0] puff_fall
);

    localparam logic [6:0] ADDR_CYCLE = 7'h20;

    logic [WIDTH-1:0] period     [NUM_IGN];
    logic [WIDTH-1:0] width      [NUM_IGN];
    logic [WIDTH-1:0] gen        [NUM_IGN];
    logic [WIDTH-1:0] period_nxt [NUM_IGN];
    logic [WIDTH-1:0] width_nxt  [NUM_IGN];
    logic [WIDTH-1:0] gen_nxt    [NUM_IGN];
    logic [NUM_IGN-1:0] reload;
    logic [WIDTH-1:0] cycle_cnt;
    logic             jiffy;

    logic [NUM_INJ-1:0] sync1;
    logic [NUM_INJ-1:0] sync2;
    logic [NUM_INJ-1:0] sync_d;
    logic [NUM_INJ-1:0] rise;
    logic [NUM_INJ-1:0] fall;
    logic [WIDTH-1:0]   run_len  [NUM_INJ];
    logic [WIDTH-1:0]   puff_cnt [NUM_INJ];
    logic [WIDTH-1:0]   puff_len [NUM_INJ];
`ifdef IGN_INJ_SIM_PUFF_MAX_EN
    logic [WIDTH-1:0]   puff_max [NUM_INJ];
`endif

    assign jiffy = sim_run & pulse50k;
    assign rise  = sync2 & ~sync_d;
    assign fall  = ~sync2 & sync_d;

    // Generator next state; coil drive is registered from these so it tracks gen exactly
    always_comb begin
        for (int i = 0; i < NUM_IGN; i++) begin
            period_nxt[i] = period[i];
            width_nxt[i]  = width[i];
            gen_nxt[i]    = gen[i];
            reload[i]     = 1'b0;
            if (reg_load && reg_addr == 7'(2 * i)) begin
                period_nxt[i] = data_in;
            end
            if (reg_load && reg_addr == 7'(2 * i + 1)) begin
                width_nxt[i] = data_in;
            end
            if (period[i] == '0) begin
                gen_nxt[i] = '0;
            end else if (jiffy) begin
                if (gen[i] == '0) begin
                    gen_nxt[i] = period[i];
                    reload[i]  = 1'b1;
                end else begin
                    gen_nxt[i] = gen[i] - WIDTH'(1);
                end
            end
        end
    end

    // Ignition channels and cycle counter
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            for (int i = 0; i < NUM_IGN; i++) begin
                period[i] <= '0;
                width[i]  <= '0;
                gen[i]    <= '0;
            end
            ign_coil_lo   <= '0;
            ign_pulse_end <= '0;
            cycle_cnt     <= '0;
        end else begin
            for (int i = 0; i < NUM_IGN; i++) begin
                period[i]      <= period_nxt[i];
                width[i]       <= width_nxt[i];
                gen[i]         <= gen_nxt[i];
                ign_coil_lo[i] <= (period_nxt[i] != '0) && (gen_nxt[i] < width_nxt[i]);
            end
            ign_pulse_end <= reload;
            if (reg_load && reg_addr == ADDR_CYCLE) begin
                cycle_cnt <= '0;
            end else if (reload[0]) begin
                cycle_cnt <= cycle_cnt + WIDTH'(1);
            end
        end
    end

    // Injector synchronizers, edge detect and puff capture; edges keep working while frozen
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            sync1     <= '0;
            sync2     <= '0;
            sync_d    <= '0;
            puff_fall <= '0;
            for (int j = 0; j < NUM_INJ; j++) begin
                run_len[j]  <= '0;
                puff_cnt[j] <= '0;
                puff_len[j] <= '0;
`ifdef IGN_INJ_SIM_PUFF_MAX_EN
                puff_max[j] <= '0;
`endif
            end
        end else begin
            sync1     <= inj_open;
            sync2     <= sync1;
            sync_d    <= sync2;
            puff_fall <= fall;
            for (int j = 0; j < NUM_INJ; j++) begin
                if (rise[j] || fall[j]) begin
                    run_len[j] <= '0;
                end else if (sync2[j] && sim_run && pulse1m && run_len[j] != {WIDTH{1'b1}}) begin
                    run_len[j] <= run_len[j] + WIDTH'(1);
                end

                if (reg_load && reg_addr == 7'(48 + 2 * j)) begin
                    puff_cnt[j] <= '0;
                end else if (fall[j]) begin
                    puff_cnt[j] <= puff_cnt[j] + WIDTH'(1);
                end

                if (reg_load && reg_addr == 7'(49 + 2 * j)) begin
                    puff_len[j] <= '0;
                end else if (fall[j]) begin
                    puff_len[j] <= run_len[j];
                end

`ifdef IGN_INJ_SIM_PUFF_MAX_EN
                if (reg_load && reg_addr == 7'(64 + j)) begin
                    puff_max[j] <= '0;
                end else if (fall[j] && !(reg_load && reg_addr == 7'(49 + 2 * j))
                             && run_len[j] > puff_max[j]) begin
                    puff_max[j] <= run_len[j];
                end
`endif
            end
        end
    end

    // Register read mux; unmapped addresses return zero
    always_comb begin
        data_out = '0;
        for (int i = 0; i < NUM_IGN; i++) begin
            if (reg_addr == 7'(2 * i)) begin
                data_out = period[i];
            end
            if (reg_addr == 7'(2 * i + 1)) begin
                data_out = width[i];
            end
        end
        if (reg_addr == ADDR_CYCLE) begin
            data_out = cycle_cnt;
        end
        for (int j = 0; j < NUM_INJ; j++) begin
            if (reg_addr == 7'(48 + 2 * j)) begin
                data_out = puff_cnt[j];
            end
            if (reg_addr == 7'(49 + 2 * j)) begin
                data_out = puff_len[j];
            end
`ifdef IGN_INJ_SIM_PUFF_MAX_EN
            if (reg_addr == 7'(64 + j)) begin
                data_out = puff_max[j];
            end
`endif
        end
    end

endmodule
